// File: rtl/fnn_pkg.sv
// fnn_pkg: shared state encoding, default dimensions and index widths for the FNN sequencer.
`default_nettype none

package fnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_MAC  = 3'd2,
        S_WB   = 3'd3,
        S_ARG  = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } fnn_seq_state_t;

    localparam int DEF_NUM_IMAGES  = 750;
    localparam int DEF_IN_LEN      = 62;
    localparam int DEF_HID_NEURONS = 30;
    localparam int DEF_OUT_NEURONS = 10;
    localparam int DEF_LANES       = 10;
    localparam int DEF_SCORE_W     = 16;

    localparam int CNT_W  = 10;
    localparam int FEAT_W = 8;
    localparam int NRN_W  = 6;
    localparam int SIDX_W = 4;
    localparam int PRED_W = 4;

endpackage

`default_nettype wire

// File: rtl/fnn_sequencer_argmax_scan.sv
// argmax_scan: running signed maximum over the output scores; strict compare keeps the lowest index on ties.
`default_nettype none

module argmax_scan
    import fnn_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int IDX_W   = PRED_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      valid,
    input  logic [IDX_W-1:0]          idx,
    input  logic signed [SCORE_W-1:0] score,
    output logic [IDX_W-1:0]          best_idx
);

    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};

    logic signed [SCORE_W-1:0] best_val;

    // Starting from the most negative value with index 0 means an all-minimum scan still reports 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_val <= MIN_SCORE;
            best_idx <= '0;
        end else if (clear) begin
            best_val <= MIN_SCORE;
            best_idx <= '0;
        end else if (valid && (score > best_val)) begin
            best_val <= score;
            best_idx <= idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fnn_sequencer.sv
// fnn_sequencer: walks each image through the hidden layer in LANES-wide passes, then the output
// layer, scans the scores for the predicted class and counts completed images.
`default_nettype none

module fnn_sequencer
    import fnn_pkg::*;
#(
    parameter int NUM_IMAGES  = DEF_NUM_IMAGES,
    parameter int IN_LEN      = DEF_IN_LEN,
    parameter int HID_NEURONS = DEF_HID_NEURONS,
    parameter int OUT_NEURONS = DEF_OUT_NEURONS,
    parameter int LANES       = DEF_LANES,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic [FEAT_W-1:0]         feat_idx,
    output logic [NRN_W-1:0]          nrn_base,
    output logic                      layer,
    output logic                      act_we,
    output logic [SIDX_W-1:0]         score_idx,
    input  logic signed [SCORE_W-1:0] score,
    output logic [PRED_W-1:0]         pred,
    output logic [CNT_W-1:0]          counter,
    output logic                      done
);

    localparam logic [FEAT_W-1:0] IN_LAST   = FEAT_W'(IN_LEN - 1);
    localparam logic [FEAT_W-1:0] HID_LAST  = FEAT_W'(HID_NEURONS - 1);
    localparam logic [SIDX_W-1:0] OUT_LAST  = SIDX_W'(OUT_NEURONS - 1);
    localparam logic [CNT_W-1:0]  CNT_FINAL = CNT_W'(NUM_IMAGES);
    localparam logic [NRN_W-1:0]  NRN_STEP  = NRN_W'(LANES);

    fnn_seq_state_t    state, state_nxt;
    logic [FEAT_W-1:0] feat_nxt;
    logic [FEAT_W-1:0] k_last;
    logic [NRN_W-1:0]  nrn_nxt;
    logic              layer_nxt;
    logic [SIDX_W-1:0] sidx_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [PRED_W-1:0] pred_nxt;
    logic [PRED_W-1:0] best_idx;
    logic              done_nxt;
    logic              last_hidden;

    assign k_last      = layer ? HID_LAST : IN_LAST;
    assign cnt_inc     = counter + CNT_W'(1);
    assign last_hidden = (int'(nrn_base) + LANES) >= HID_NEURONS;

    argmax_scan #(
        .SCORE_W (SCORE_W),
        .IDX_W   (PRED_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == S_CLR) && layer),
        .valid    (state == S_ARG),
        .idx      (score_idx),
        .score    (score),
        .best_idx (best_idx)
    );

    // Index registers double as the per-state step counters; they fall back to 0 outside their state.
    always_comb begin
        state_nxt = state;
        feat_nxt  = '0;
        sidx_nxt  = '0;
        nrn_nxt   = nrn_base;
        layer_nxt = layer;
        cnt_nxt   = counter;
        pred_nxt  = pred;
        done_nxt  = done;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLR;
                    cnt_nxt   = '0;
                    layer_nxt = 1'b0;
                    nrn_nxt   = '0;
                end
            end
            S_CLR: begin
                state_nxt = S_MAC;
            end
            S_MAC: begin
                if (feat_idx == k_last) begin
                    state_nxt = S_WB;
                end else begin
                    feat_nxt = feat_idx + FEAT_W'(1);
                end
            end
            S_WB: begin
                if (layer) begin
                    state_nxt = S_ARG;
                end else if (!last_hidden) begin
                    nrn_nxt   = nrn_base + NRN_STEP;
                    state_nxt = S_CLR;
                end else begin
                    layer_nxt = 1'b1;
                    nrn_nxt   = '0;
                    state_nxt = S_CLR;
                end
            end
            S_ARG: begin
                if (score_idx == OUT_LAST) begin
                    state_nxt = S_NEXT;
                end else begin
                    sidx_nxt = score_idx + SIDX_W'(1);
                end
            end
            S_NEXT: begin
                pred_nxt  = best_idx;
                cnt_nxt   = cnt_inc;
                layer_nxt = 1'b0;
                nrn_nxt   = '0;
                if (cnt_inc == CNT_FINAL) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = S_CLR;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_CLR;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            act_we    <= 1'b0;
            feat_idx  <= '0;
            score_idx <= '0;
            nrn_base  <= '0;
            layer     <= 1'b0;
            counter   <= '0;
            pred      <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mac_clr   <= (state_nxt == S_CLR);
            mac_en    <= (state_nxt == S_MAC);
            act_we    <= (state_nxt == S_WB) && !layer_nxt;
            feat_idx  <= feat_nxt;
            score_idx <= sidx_nxt;
            nrn_base  <= nrn_nxt;
            layer     <= layer_nxt;
            counter   <= cnt_nxt;
            pred      <= pred_nxt;
            done      <= done_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fnn_sequencer.sv
// tb_fnn_sequencer: cycle-schedule model plus a prediction scoreboard for fnn_sequencer (3-image runs).
`default_nettype none

module tb_fnn_sequencer;

    localparam int NI        = 3;
    localparam int HID_PASS  = 1 + 62 + 1;
    localparam int OUT_PASS  = 1 + 30 + 1;
    localparam int PER       = 3 * HID_PASS + OUT_PASS + 10 + 1;
    localparam int DONE_CYC  = NI * PER + 1;

    typedef struct {
        logic [3:0] pred;
        logic [9:0] cnt;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               start;
    logic               mac_clr;
    logic               mac_en;
    logic [7:0]         feat_idx;
    logic [5:0]         nrn_base;
    logic               layer;
    logic               act_we;
    logic [3:0]         score_idx;
    logic signed [15:0] score;
    logic [3:0]         pred;
    logic [9:0]         counter;
    logic               done;

    logic signed [15:0] scores [NI][10];
    exp_t               sbq [$];

    int  vectors;
    int  miscompares;
    bit  active;
    int  cyc;
    bit  final_req;
    bit  final_done;
    logic [9:0] prev_cnt;

    fnn_sequencer #(
        .NUM_IMAGES  (NI),
        .IN_LEN      (62),
        .HID_NEURONS (30),
        .OUT_NEURONS (10),
        .LANES       (10),
        .SCORE_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .feat_idx  (feat_idx),
        .nrn_base  (nrn_base),
        .layer     (layer),
        .act_we    (act_we),
        .score_idx (score_idx),
        .score     (score),
        .pred      (pred),
        .counter   (counter),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        score = '0;
        if (int'(counter) < NI && int'(score_idx) < 10)
            score = scores[int'(counter)][int'(score_idx)];
    end

    // Expected outputs for cycle c of a run (cycle 1 follows the start edge), from the stage schedule.
    function automatic logic [32:0] model(int c);
        logic clr, en, ly, we, dn;
        int   f, nb, si, cn, o, q;
        clr = 0; en = 0; ly = 0; we = 0; dn = 0;
        f = 0; nb = 0; si = 0; cn = 0;
        if (c >= DONE_CYC) begin
            cn = NI;
            dn = 1;
        end else begin
            o  = (c - 1) % PER;
            cn = (c - 1) / PER;
            if (o < 3 * HID_PASS) begin
                q   = o % HID_PASS;
                nb  = (o / HID_PASS) * 10;
                clr = (q == 0);
                en  = (q >= 1 && q <= 62);
                f   = en ? q - 1 : 0;
                we  = (q == HID_PASS - 1);
            end else if (o < 3 * HID_PASS + OUT_PASS) begin
                q   = o - 3 * HID_PASS;
                ly  = 1;
                clr = (q == 0);
                en  = (q >= 1 && q <= 30);
                f   = en ? q - 1 : 0;
            end else if (o < PER - 1) begin
                ly = 1;
                si = o - (3 * HID_PASS + OUT_PASS);
            end else begin
                ly = 1;
            end
        end
        return {clr, en, 8'(f), 6'(nb), ly, we, 4'(si), 10'(cn), dn};
    endfunction

    function automatic logic [3:0] ref_argmax(int img);
        int best, bi;
        best = int'(scores[img][0]);
        bi   = 0;
        for (int i = 1; i < 10; i++) begin
            if (int'(scores[img][i]) > best) begin
                best = int'(scores[img][i]);
                bi   = i;
            end
        end
        return 4'(bi);
    endfunction

    // Run tracker: which cycle of the schedule the DUT should be in.
    always @(posedge clk) begin
        if (!rst) begin
            active = 0;
            cyc    = 0;
        end else if (start && (!active || cyc >= DONE_CYC)) begin
            active = 1;
            cyc    = 1;
        end else if (active && cyc < DONE_CYC) begin
            cyc = cyc + 1;
        end
    end

    // Monitor: per-cycle schedule compare and prediction scoreboard.
    initial begin
        vectors     = 0;
        miscompares = 0;
        final_done  = 0;
        prev_cnt    = '0;
    end

    always @(negedge clk) begin
        logic [32:0] exp_v, got_v;
        exp_t        e;
        got_v = {mac_clr, mac_en, feat_idx, nrn_base, layer, act_we, score_idx, counter, done};
        if (!rst || !active) exp_v = '0;
        else                 exp_v = model(cyc);
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL sched cyc=%0d got=%h exp=%h", cyc, got_v, exp_v);
        end
        if (!rst) begin
            vectors++;
            if (pred !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_pred got=%0d exp=0", pred);
            end
            sbq.delete();
            prev_cnt = '0;
        end else if (counter !== prev_cnt) begin
            if (counter != 10'd0) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected counter=%0d pred=%0d exp=none", counter, pred);
                end else begin
                    e = sbq.pop_front();
                    if (pred !== e.pred || counter !== e.cnt) begin
                        miscompares++;
                        $display("FAIL sb_pred got pred=%0d cnt=%0d exp pred=%0d cnt=%0d",
                                 pred, counter, e.pred, e.cnt);
                    end
                end
            end
            prev_cnt = counter;
        end
        if (final_req && !final_done) begin
            final_done = 1;
            vectors++;
            if (sbq.size() != 0) begin
                miscompares++;
                $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
            end
        end
    end

    task automatic load_image(int img, int mode);
        for (int i = 0; i < 10; i++) begin
            case (mode)
                0:       scores[img][i] = 16'(int'($urandom_range(200)) - 100);
                1:       scores[img][i] = 16'(-1 - int'($urandom_range(999)));
                2:       scores[img][i] = -16'sd1;
                default: scores[img][i] = 16'($urandom);
            endcase
        end
        if (mode == 0) scores[img][7] = 16'sd120;
        if (mode == 1) begin
            scores[img][2] = 16'sd50;
            scores[img][5] = 16'sd50;
        end
    endtask

    task automatic load_run(int m0, int m1, int m2);
        exp_t e;
        load_image(0, m0);
        load_image(1, m1);
        load_image(2, m2);
        for (int img = 0; img < NI; img++) begin
            e.pred = ref_argmax(img);
            e.cnt  = 10'(img + 1);
            sbq.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < DONE_CYC + 20 && !done; i++) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        final_req = 0;
        for (int a = 0; a < NI; a++)
            for (int b = 0; b < 10; b++) scores[a][b] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: max at 7, tie at 2/5, all equal.
        load_run(0, 1, 2);
        pulse_start();
        wait_done();
        repeat (5) @(negedge clk);

        // Run 2 from DONE, with a stray start during MAC.
        load_run(3, 3, 3);
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // Run 3: aborted by an asynchronous reset mid-MAC.
        load_run(3, 3, 3);
        pulse_start();
        repeat (120) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Run 4 from IDLE after reset.
        load_run(3, 1, 3);
        pulse_start();
        wait_done();
        repeat (3) @(negedge clk);

        final_req = 1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
